ecp_dbl_seq: RTL and testbench

ECP_DBL_SEQ -- requirements
Module: ecp_dbl_seq

---
 rtl/ecp_dbl_seq.sv | 179 +++++++++++++++++
 tb/tb_ecp_dbl_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ecp_dbl_seq.sv
// ecp_dbl_seq: Jacobian point doubling mod p on one shared mul/add/sub datapath sequenced by a fixed microcode table.
// Build option ECPD_A_MINUS3_EN selects M = 3*(X1-Z1^2)*(X1+Z1^2) for a=-3 curves.
module ecp_dbl_seq #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] Y1,
    input  logic [WIDTH-1:0] Z1,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] X3,
    output logic [WIDTH-1:0] Y3,
    output logic [WIDTH-1:0] Z3,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_inf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_MUL = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2;
    localparam logic [3:0] R_X1 = 4'd0, R_Y1 = 4'd1, R_Z1 = 4'd2, R_XX = 4'd3, R_B = 4'd4, R_S = 4'd5,
                           R_T = 4'd6, R_M = 4'd7, R_Z3 = 4'd8, R_X3 = 4'd9, R_U = 4'd10, R_Y3 = 4'd11;
    // each word: {op, src_a, src_b, dst}; R_XX holds 3M/3 before the two M adds
`ifdef ECPD_A_MINUS3_EN
    localparam logic [3:0] R_ZZ = 4'd12, R_D = 4'd13, R_E = 4'd14;
    localparam int NSTEPS = 22;
    localparam logic [13:0] UC [NSTEPS] = '{
        {OP_MUL, R_Z1, R_Z1, R_ZZ}, {OP_SUB, R_X1, R_ZZ, R_D}, {OP_ADD, R_X1, R_ZZ, R_E},
        {OP_MUL, R_D, R_E, R_XX}, {OP_ADD, R_XX, R_XX, R_M}, {OP_ADD, R_M, R_XX, R_M},
        {OP_MUL, R_Y1, R_Y1, R_B}, {OP_MUL, R_X1, R_B, R_S}, {OP_ADD, R_S, R_S, R_S},
        {OP_ADD, R_S, R_S, R_S}, {OP_MUL, R_B, R_B, R_T}, {OP_ADD, R_T, R_T, R_T},
        {OP_ADD, R_T, R_T, R_T}, {OP_ADD, R_T, R_T, R_T}, {OP_MUL, R_Y1, R_Z1, R_Z3},
        {OP_ADD, R_Z3, R_Z3, R_Z3}, {OP_MUL, R_M, R_M, R_X3}, {OP_SUB, R_X3, R_S, R_X3},
        {OP_SUB, R_X3, R_S, R_X3}, {OP_SUB, R_S, R_X3, R_U}, {OP_MUL, R_M, R_U, R_Y3},
        {OP_SUB, R_Y3, R_T, R_Y3}
    };
`else
    localparam int NSTEPS = 19;
    localparam logic [13:0] UC [NSTEPS] = '{
        {OP_MUL, R_X1, R_X1, R_XX}, {OP_MUL, R_Y1, R_Y1, R_B}, {OP_MUL, R_X1, R_B, R_S},
        {OP_ADD, R_S, R_S, R_S}, {OP_ADD, R_S, R_S, R_S}, {OP_MUL, R_B, R_B, R_T},
        {OP_ADD, R_T, R_T, R_T}, {OP_ADD, R_T, R_T, R_T}, {OP_ADD, R_T, R_T, R_T},
        {OP_ADD, R_XX, R_XX, R_M}, {OP_ADD, R_M, R_XX, R_M}, {OP_MUL, R_Y1, R_Z1, R_Z3},
        {OP_ADD, R_Z3, R_Z3, R_Z3}, {OP_MUL, R_M, R_M, R_X3}, {OP_SUB, R_X3, R_S, R_X3},
        {OP_SUB, R_X3, R_S, R_X3}, {OP_SUB, R_S, R_X3, R_U}, {OP_MUL, R_M, R_U, R_Y3},
        {OP_SUB, R_Y3, R_T, R_Y3}
    };
`endif
    localparam logic [4:0] LAST_STEP = 5'(NSTEPS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ADD, S_SUB, S_DONE} state_t;

    function automatic state_t op_st(input logic [1:0] op);
        return op == OP_MUL ? S_MUL : op == OP_ADD ? S_ADD : S_SUB;
    endfunction

    state_t state_q, state_d;
    logic [4:0] step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, ma_q, ma_d, p_q, p_d;
    logic [WIDTH-1:0] rf_q [16];
    logic [WIDTH-1:0] rf_d [16];
    logic [WIDTH-1:0] x3_q, x3_d, y3_q, y3_d, z3_q, z3_d;
    logic inf_q, inf_d, fin;
    logic [3:0] ua, ub, ud;
    logic [1:0] nop;
    logic [WIDTH-1:0] opa, opb, dbl_r, mul_r, add_r, sub_r;
    logic [WIDTH:0] pe, dbl, msum, sum, dif;

    assign ua = UC[step_q][11:8];
    assign ub = UC[step_q][7:4];
    assign ud = UC[step_q][3:0];
    assign nop = UC[state_q == S_LOAD ? 5'd0 : step_q + 5'd1][13:12];
    assign opa = rf_q[ua];
    assign opb = rf_q[ub];
    assign pe = {1'b0, p_q};
    // one interleaved-multiply bit: r = 2r mod p, then r += b mod p when the multiplier bit is set
    assign dbl = {acc_q, 1'b0};
    assign dbl_r = dbl >= pe ? WIDTH'(dbl - pe) : dbl[WIDTH-1:0];
    assign msum = {1'b0, dbl_r} + {1'b0, opb};
    assign mul_r = !ma_q[WIDTH-1] ? dbl_r : msum >= pe ? WIDTH'(msum - pe) : msum[WIDTH-1:0];
    assign sum = {1'b0, opa} + {1'b0, opb};
    assign add_r = sum >= pe ? WIDTH'(sum - pe) : sum[WIDTH-1:0];
    assign dif = {1'b0, opa} - {1'b0, opb};
    assign sub_r = dif[WIDTH] ? dif[WIDTH-1:0] + p_q : dif[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        step_d = step_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        ma_d = ma_q;
        p_d = p_q;
        rf_d = rf_q;
        x3_d = x3_q;
        y3_d = y3_q;
        z3_d = z3_q;
        inf_d = inf_q;
        fin = 1'b0;
        case (state_q)
            S_IDLE: if (i_start) begin
                state_d = S_LOAD;
                rf_d[R_X1] = X1;
                rf_d[R_Y1] = Y1;
                rf_d[R_Z1] = Z1;
                p_d = p;
                inf_d = 1'b0;
            end
            S_LOAD: begin
                state_d = op_st(nop);
                step_d = '0;
                cnt_d = '0;
            end
            S_MUL: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = cnt_q == '0 ? '0 : mul_r;
                ma_d = cnt_q == '0 ? opa : ma_q << 1;
                if (cnt_q == CW'(WIDTH)) begin
                    rf_d[ud] = mul_r;
                    fin = 1'b1;
                end
            end
            S_ADD: begin
                rf_d[ud] = add_r;
                fin = 1'b1;
            end
            S_SUB: begin
                rf_d[ud] = sub_r;
                fin = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (fin) begin
            step_d = step_q + 5'd1;
            cnt_d = '0;
            state_d = step_q == LAST_STEP ? S_DONE : op_st(nop);
            if (step_q == LAST_STEP) begin
                x3_d = rf_d[R_X3];
                y3_d = rf_d[R_Y3];
                z3_d = rf_d[R_Z3];
                inf_d = rf_d[R_Z3] == '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            step_q <= '0;
            x3_q <= '0;
            y3_q <= '0;
            z3_q <= '0;
            inf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q <= step_d;
            x3_q <= x3_d;
            y3_q <= y3_d;
            z3_q <= z3_d;
            inf_q <= inf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        cnt_q <= cnt_d;
        acc_q <= acc_d;
        ma_q <= ma_d;
        p_q <= p_d;
        rf_q <= rf_d;
    end

    assign X3 = x3_q;
    assign Y3 = y3_q;
    assign Z3 = z3_q;
    assign o_busy = state_q != S_IDLE;
    assign o_done = state_q == S_DONE;
    assign o_inf = inf_q;
endmodule

// File: tb/tb_ecp_dbl_seq.sv
// tb_ecp_dbl_seq: known-answer vectors, start/reset corner sequences and random operations
// checked against an arithmetic model of Jacobian doubling, at WIDTH=8.
module tb_ecp_dbl_seq;
    localparam int W = 8;
`ifdef ECPD_A_MINUS3_EN
    localparam int LAT = 8 * (W + 1) + 15;
`else
    localparam int LAT = 7 * (W + 1) + 13;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] x1 = '0, y1 = '0, z1 = '0, pm = 8'd251;
    logic [W-1:0] x3, y3, z3;
    logic busy, done, inf;
    int n_vec = 0, n_err = 0, cyc = 0, acc_cyc = 0;

    typedef struct { int x, y, z, pp, ex, ey, ez, einf; } vec_t;
    vec_t tbl [4];
    int primes [10] = '{251, 241, 233, 199, 127, 97, 13, 11, 7, 5};

    ecp_dbl_seq #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .X1(x1), .Y1(y1), .Z1(z1), .p(pm),
        .X3(x3), .Y3(y3), .Z3(z3),
        .o_busy(busy), .o_done(done), .o_inf(inf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model(input int x, y, z, pp, output int ex, ey, ez);
        longint m, s, t, yy, u;
        yy = longint'(y) * y % pp;
        s = 4 * x * yy % pp;
        t = 8 * yy * yy % pp;
`ifdef ECPD_A_MINUS3_EN
        u = longint'(z) * z % pp;
        m = 3 * ((x - u + pp) % pp) * ((x + u) % pp) % pp;
`else
        u = 0;
        m = (3 * longint'(x) * x + u) % pp;
`endif
        ex = int'((m * m % pp + 2 * pp - 2 * s) % pp);
        ey = int'((m * ((s - ex + pp) % pp) % pp + pp - t) % pp);
        ez = int'(2 * longint'(y) * z % pp);
    endfunction

    task automatic start_op(input string nm, input int x, y, z, pp);
        @(negedge clk);
        for (int k = 0; k < 300 && busy; k++) @(negedge clk);
        x1 = W'(x); y1 = W'(y); z1 = W'(z); pm = W'(pp);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_cyc = cyc;
        chk({nm, "_accept_busy"}, busy, 1);
    endtask

    task automatic wait_done(output int lat);
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk);
            #1;
        end
        lat = done ? cyc - acc_cyc : -1;
    endtask

    task automatic check_res(input string nm, input int lat, input vec_t v);
        chk({nm, "_lat"}, lat, LAT);
        chk({nm, "_x3"}, x3, v.ex);
        chk({nm, "_y3"}, y3, v.ey);
        chk({nm, "_z3"}, z3, v.ez);
        chk({nm, "_inf"}, inf, v.einf);
    endtask

    task automatic run_case(input string nm, input vec_t v);
        int lat;
        start_op(nm, v.x, v.y, v.z, v.pp);
        wait_done(lat);
        check_res(nm, lat, v);
    endtask

    initial begin
        int lat, seen;
        vec_t v;
`ifdef ECPD_A_MINUS3_EN
        tbl[0] = '{2, 3, 1, 251, 188, 65, 6, 0};
        tbl[1] = '{5, 0, 1, 251, 164, 240, 0, 1};
        tbl[2] = '{7, 1, 0, 251, 218, 174, 0, 1};
        tbl[3] = '{1, 1, 1, 251, 243, 243, 2, 0};
`else
        tbl[0] = '{2, 3, 1, 251, 0, 216, 6, 0};
        tbl[1] = '{5, 0, 1, 251, 103, 56, 0, 1};
        tbl[2] = '{7, 1, 0, 251, 218, 174, 0, 1};
        tbl[3] = '{1, 1, 1, 251, 1, 1, 2, 0};
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x3", x3, 0);
        chk("rst_y3", y3, 0);
        chk("rst_z3", z3, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_inf", inf, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_case($sformatf("tbl%0d", i), tbl[i]);

        @(posedge clk);
        #1;
        chk("done_single_pulse", done, 0);

        // inputs change mid-operation and a stray start pulse must both be ignored
        start_op("ign", 2, 3, 1, 251);
        repeat (5) @(negedge clk);
        x1 = 8'd9;
        repeat (15) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check_res("ign", lat, tbl[0]);

        // level-high start re-triggers once back in IDLE, using the inputs present then
        start_op("b2b1", 1, 1, 1, 251);
        start = 1'b1;
        x1 = 8'd2; y1 = 8'd3; z1 = 8'd1;
        wait_done(lat);
        check_res("b2b1", lat, tbl[3]);
        @(posedge clk);
        #1;
        chk("b2b_idle_busy", busy, 0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start = 1'b0;
        chk("b2b_reaccept_busy", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_hold_x3", x3, tbl[3].ex);
        chk("b2b_hold_y3", y3, tbl[3].ey);
        wait_done(lat);
        check_res("b2b2", lat, tbl[0]);

        // asynchronous reset mid-operation aborts without o_done
        start_op("abort", 7, 1, 0, 251);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_x3", x3, 0);
        chk("abort_y3", y3, 0);
        chk("abort_z3", z3, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (LAT + 10) begin
            @(posedge clk);
            #1;
            seen |= int'(done | busy);
        end
        chk("abort_no_done", seen, 0);
        run_case("restart", tbl[0]);

        for (int i = 0; i < 25; i++) begin
            v.pp = primes[$urandom_range(0, 9)];
            v.x = $urandom_range(0, v.pp - 1);
            v.y = $urandom_range(0, v.pp - 1);
            v.z = (i % 8 == 3) ? 0 : $urandom_range(0, v.pp - 1);
            model(v.x, v.y, v.z, v.pp, v.ex, v.ey, v.ez);
            v.einf = v.ez == 0 ? 1 : 0;
            run_case($sformatf("rnd%0d_p%0d_%0d_%0d_%0d", i, v.pp, v.x, v.y, v.z), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
